// File: rtl/estufa_zonas.sv
// estufa_zonas: multi-zone greenhouse motor controller with debounce, min on/off, timeout fault and manual override
module estufa_zonas #(
  parameter int N_ZONAS    = 4,
  parameter int DEB_CYCLES = 4,
  parameter int MIN_ON     = 8,
  parameter int MIN_OFF    = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_ZONAS-1:0] luz,
  input  logic [N_ZONAS-1:0] umid,
  input  logic [N_ZONAS-1:0] fim_e,
  input  logic [N_ZONAS-1:0] fim_d,
  input  logic               man_en,
  input  logic [N_ZONAS-1:0] man_mh,
  input  logic [N_ZONAS-1:0] clr_fault,
  output logic [N_ZONAS-1:0] mh,
  output logic [N_ZONAS-1:0] ma,
  output logic [N_ZONAS-1:0] fault,
  output logic               fault_any
);
  localparam int NS = 4 * N_ZONAS;
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, FLT} state_t;
  logic [NS-1:0] raw, deb;
  logic [N_ZONAS-1:0] luz_d, umid_d, fe_d, fd_d, req, mh_n, fault_n;
  assign raw = {fim_d, fim_e, umid, luz};
  assign {fd_d, fe_d, umid_d, luz_d} = deb;
  for (genvar b = 0; b < NS; b++) begin : g_deb
    logic d;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk)
      if (reset) begin
        d   <= 1'b0;
        cnt <= '0;
      end else if (raw[b] == d) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        d   <= raw[b];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    assign deb[b] = d;
  end
  for (genvar z = 0; z < N_ZONAS; z++) begin : g_zone
    state_t st, nst;
    logic [TW-1:0] tmr, ntmr;
    assign req[z] = (man_en ? man_mh[z] : (umid_d[z] | luz_d[z])) & ~fd_d[z];
    always_ff @(posedge clk)
      if (reset) begin
        st  <= IDLE;
        tmr <= '0;
      end else begin
        st  <= nst;
        tmr <= ntmr;
      end
    // tmr counts completed RUN cycles, so tmr+1 >= MIN_ON means MIN_ON cycles of mh high
    always_comb begin
      nst  = st;
      ntmr = tmr + 1'b1;
      unique case (st)
        IDLE: begin
          ntmr = '0;
          nst  = req[z] ? RUN : IDLE;
        end
        RUN:
          if (fd_d[z] || (!req[z] && tmr >= TW'(MIN_ON - 1))) begin
            nst  = HOLD;
            ntmr = '0;
          end else if (tmr == TW'(TIMEOUT - 1)) nst = FLT;
        HOLD:
          if (tmr == TW'(MIN_OFF - 1)) begin
            nst  = IDLE;
            ntmr = '0;
          end
        FLT: begin
          ntmr = '0;
          nst  = clr_fault[z] ? HOLD : FLT;
        end
      endcase
    end
    always_comb begin
      mh_n[z]    = nst == RUN;
      fault_n[z] = nst == FLT;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      mh        <= '0;
      ma        <= '0;
      fault     <= '0;
      fault_any <= 1'b0;
    end else begin
      mh        <= mh_n;
      ma        <= ~(fe_d & luz_d & umid_d);
      fault     <= fault_n;
      fault_any <= |fault_n;
    end
endmodule

// File: tb/tb_estufa_zonas.sv
// tb_estufa_zonas: vector table with scoreboard plus timed sequences for estufa_zonas
module tb_estufa_zonas;
  logic clk = 1'b0, reset = 1'b0, man_en = 1'b0, fault_any;
  logic [3:0] luz = '0, umid = '0, fim_e = '0, fim_d = '0, man_mh = '0, clr_fault = '0;
  logic [3:0] mh, ma, fault;
  int total = 0, passed = 0;
  typedef struct {
    string name;
    logic [3:0] luz, umid, fe, fd;
    int n;
    logic [3:0] mh, ma, flt;
    logic fa;
  } vec_t;
  typedef struct {
    string name;
    logic [3:0] mh, ma, flt;
    logic fa;
  } exp_t;
  vec_t tbl[8];
  exp_t sb[$];
  exp_t e;
  estufa_zonas dut (
    .clk(clk), .reset(reset), .luz(luz), .umid(umid), .fim_e(fim_e), .fim_d(fim_d),
    .man_en(man_en), .man_mh(man_mh), .clr_fault(clr_fault),
    .mh(mh), .ma(ma), .fault(fault), .fault_any(fault_any)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else passed++;
  endtask
  task automatic do_reset(input int n);
    reset = 1'b1;
    man_en = 1'b0;
    man_mh = '0;
    clr_fault = '0;
    repeat (n) begin
      luz = 4'($urandom);
      umid = 4'($urandom);
      fim_e = 4'($urandom);
      fim_d = 4'($urandom);
      tick();
    end
    reset = 1'b0;
    {luz, umid, fim_e, fim_d} = '0;
  endtask
  initial begin
    int n, k;
    logic seen;
    tbl[0] = '{"idle",       4'h0, 4'h0, 4'h0, 4'h0, 1,  4'h0, 4'hF, 4'h0, 1'b0};
    tbl[1] = '{"deb_wait",   4'hF, 4'h0, 4'hF, 4'h0, 3,  4'h0, 4'hF, 4'h0, 1'b0};
    tbl[2] = '{"deb_accept", 4'hF, 4'h0, 4'hF, 4'h0, 1,  4'h0, 4'hF, 4'h0, 1'b0};
    tbl[3] = '{"luz_run",    4'hF, 4'h0, 4'hF, 4'h0, 1,  4'hF, 4'hF, 4'h0, 1'b0};
    tbl[4] = '{"umid_ma",    4'hF, 4'hF, 4'hF, 4'h0, 5,  4'hF, 4'h0, 4'h0, 1'b0};
    tbl[5] = '{"fe_mix",     4'hF, 4'hF, 4'h5, 4'h0, 5,  4'hF, 4'hA, 4'h0, 1'b0};
    tbl[6] = '{"fd_stop",    4'hF, 4'hF, 4'h5, 4'h3, 5,  4'hC, 4'hA, 4'h0, 1'b0};
    tbl[7] = '{"all_off",    4'h0, 4'h0, 4'h5, 4'h0, 10, 4'h0, 4'hF, 4'h0, 1'b0};
    // reset state and first edge
    do_reset(3);
    chk("rst_mh", mh, 4'h0);
    chk("rst_ma", ma, 4'h0);
    chk("rst_fault", fault, 4'h0);
    chk("rst_fault_any", fault_any, 1'b0);
    // vector table, expectations queued on drive and popped at sample time
    for (int i = 0; i < 8; i++) begin
      luz = tbl[i].luz;
      umid = tbl[i].umid;
      fim_e = tbl[i].fe;
      fim_d = tbl[i].fd;
      sb.push_back('{tbl[i].name, tbl[i].mh, tbl[i].ma, tbl[i].flt, tbl[i].fa});
      repeat (tbl[i].n) tick();
      e = sb.pop_front();
      chk({e.name, "_mh"}, mh, e.mh);
      chk({e.name, "_ma"}, ma, e.ma);
      chk({e.name, "_fault"}, fault, e.flt);
      chk({e.name, "_fault_any"}, fault_any, e.fa);
    end
    // glitch rejection, latency, MIN_ON and MIN_OFF on zone 0
    do_reset(3);
    tick();
    chk("ma_first_edge", ma, 4'hF);
    umid = 4'b0001;
    repeat (3) tick();
    umid = '0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= mh[0];
    end
    chk("glitch_mh0", seen, 1'b0);
    umid = 4'b0001;
    repeat (4) tick();
    chk("lat_edge4_mh0", mh[0], 1'b0);
    tick();
    chk("lat_edge5_mh0", mh[0], 1'b1);
    repeat (2) tick();
    umid = '0;
    n = 3;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!mh[0]) break;
      n++;
    end
    chk("min_on_cycles", n, 8);
    umid = 4'b0001;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      k++;
      if (mh[0]) break;
    end
    chk("min_off_rise", k, 9);
    // end-stop overrides MIN_ON on zone 1
    do_reset(3);
    umid = 4'b0010;
    repeat (5) tick();
    chk("z1_run", mh[1], 1'b1);
    repeat (2) tick();
    fim_d = 4'b0010;
    repeat (4) tick();
    chk("fd_edge4_mh1", mh[1], 1'b1);
    tick();
    chk("fd_edge5_mh1", mh[1], 1'b0);
    // timeout fault and clear on zone 2
    do_reset(3);
    umid = 4'b0100;
    repeat (5) tick();
    chk("z2_run", mh[2], 1'b1);
    n = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!mh[2]) break;
      n++;
    end
    chk("timeout_cycles", n, 64);
    chk("timeout_fault", fault, 4'b0100);
    chk("timeout_fault_any", fault_any, 1'b1);
    repeat (3) tick();
    chk("fault_latched", {mh[2], fault[2]}, 2'b01);
    clr_fault = 4'b0100;
    tick();
    clr_fault = '0;
    chk("clr_fault", fault, 4'h0);
    chk("clr_fault_any", fault_any, 1'b0);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      k++;
      if (mh[2]) break;
    end
    chk("clr_rerun", k, 9);
    // manual mode from idle
    do_reset(3);
    man_en = 1'b1;
    man_mh = 4'b1000;
    umid = 4'hF;
    luz = 4'hF;
    fim_e = 4'hF;
    tick();
    chk("man_next_edge", mh, 4'b1000);
    repeat (4) tick();
    chk("man_hold", mh, 4'b1000);
    chk("man_ma", ma, 4'h0);
    // manual switch while running still honours MIN_ON
    do_reset(3);
    umid = 4'hF;
    repeat (5) tick();
    chk("auto_run_all", mh, 4'hF);
    repeat (2) tick();
    man_en = 1'b1;
    man_mh = 4'b1000;
    repeat (5) tick();
    chk("man_min_on", mh, 4'hF);
    tick();
    chk("man_drop", mh, 4'b1000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midop_reset", mh, 4'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
